// File: rtl/rf_write_arbiter.sv
// Two-requester write-port arbiter for the 24-bit x 16 register file.
// Optional read bypass enabled by defining RF_WRITE_BYPASS_EN.
module rf_write_arbiter #(
   parameter int STARVE_LIMIT     = 3,
   parameter bit ZERO_REG_PROTECT = 1'b1
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic        AValid,
   output logic        AReady,
   input  logic [3:0]  ARD,
   input  logic [23:0] AData,
   input  logic        BValid,
   output logic        BReady,
   input  logic [3:0]  BRD,
   input  logic [23:0] BData,
   output logic [3:0]  RD,
   output logic [23:0] WriteData,
   output logic        RegWrite,
   output logic        GrantB
`ifdef RF_WRITE_BYPASS_EN
   ,
   input  logic [3:0]  RS,
   input  logic [3:0]  RT,
   input  logic [23:0] RFReadRS,
   input  logic [23:0] RFReadRT,
   output logic [23:0] FwdRS,
   output logic [23:0] FwdRT
`endif
);

   typedef enum logic {
      PRI_A,
      PRI_B
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   state_t     stateNext;
   logic [3:0] starveCnt;
   logic [3:0] cntNext;
   logic       aXfer;
   logic       bXfer;

   always_comb begin
      AReady = 1'b0;
      BReady = 1'b0;
      if (ResetN) begin
         unique case (state)
            PRI_A: begin
               AReady = AValid;
               BReady = BValid && !AValid;
            end
            PRI_B: begin
               BReady = BValid;
            end
            default: ;
         endcase
      end
   end

   assign aXfer = AValid && AReady;
   assign bXfer = BValid && BReady;

   // Counter only builds while B is waiting and refused.
   always_comb begin
      stateNext = state;
      cntNext   = starveCnt;
      unique case (state)
         PRI_A: begin
            if (bXfer || !BValid) begin
               cntNext = 4'd0;
            end else begin
               cntNext = (starveCnt >= LIMIT) ? LIMIT
                                              : starveCnt + 4'd1;
               if (cntNext == LIMIT) stateNext = PRI_B;
            end
         end
         PRI_B: begin
            if (bXfer || !BValid) begin
               stateNext = PRI_A;
               cntNext   = 4'd0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state     <= PRI_A;
         starveCnt <= 4'd0;
         RD        <= 4'd0;
         WriteData <= 24'd0;
         RegWrite  <= 1'b0;
         GrantB    <= 1'b0;
      end else begin
         state     <= stateNext;
         starveCnt <= cntNext;
         RegWrite  <= 1'b0;
         GrantB    <= 1'b0;
         if (aXfer) begin
            RD        <= ARD;
            WriteData <= AData;
            RegWrite  <= !(ZERO_REG_PROTECT && ARD == 4'd0);
         end else if (bXfer) begin
            RD        <= BRD;
            WriteData <= BData;
            RegWrite  <= !(ZERO_REG_PROTECT && BRD == 4'd0);
            GrantB    <= 1'b1;
         end
      end
   end

`ifdef RF_WRITE_BYPASS_EN
   // Covers the read-during-write cycle before the file has the value.
   assign FwdRS = (RegWrite && RD == RS &&
                   !(ZERO_REG_PROTECT && RS == 4'd0)) ? WriteData
                                                      : RFReadRS;
   assign FwdRT = (RegWrite && RD == RT &&
                   !(ZERO_REG_PROTECT && RT == 4'd0)) ? WriteData
                                                      : RFReadRT;
`endif

endmodule
